// File: rtl/zoom_pkg.sv
// Shared types and constants for the 2:1 frame decimation engine feeding the VGA framebuffer.
package zoom_pkg;

    localparam int SRC_W_DEF  = 320;
    localparam int SRC_H_DEF  = 240;
    localparam int DST_W_DEF  = SRC_W_DEF / 2;
    localparam int DST_H_DEF  = SRC_H_DEF / 2;
    localparam int ADDR_W_DEF = 17;
    localparam int DATA_W_DEF = 8;

    localparam logic MODE_NEAREST = 1'b0;
    localparam logic MODE_MEAN    = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/decim_addr_gen.sv
// Output-pixel and sample counters; presents the source address for the counters' next value
// so the top can register it on the same edge the counters move.
module decim_addr_gen
    import zoom_pkg::*;
#(
    parameter int SRC_W  = SRC_W_DEF,
    parameter int SRC_H  = SRC_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear_i,
    input  logic              adv_sample_i,
    input  logic              adv_pixel_i,
    input  logic              mean_i,
    output logic [ADDR_W-1:0] src_addr_nxt_o,
    output logic [ADDR_W-1:0] dst_addr_o,
    output logic              last_sample_o,
    output logic              last_pixel_o
);

    localparam int DST_W = SRC_W / 2;
    localparam int DST_H = SRC_H / 2;
    localparam int OX_W  = $clog2(DST_W);
    localparam int OY_W  = $clog2(DST_H);

    logic [OX_W-1:0]   ox_q, ox_d;
    logic [OY_W-1:0]   oy_q, oy_d;
    logic [1:0]        s_q, s_d;
    logic [ADDR_W-1:0] row, col;

    always_comb begin
        ox_d = ox_q;
        oy_d = oy_q;
        s_d  = s_q;
        if (clear_i) begin
            ox_d = '0;
            oy_d = '0;
            s_d  = '0;
        end else if (adv_sample_i) begin
            s_d = s_q + 2'd1;
        end else if (adv_pixel_i) begin
            s_d = '0;
            if (ox_q == OX_W'(DST_W - 1)) begin
                ox_d = '0;
                oy_d = oy_q + 1'b1;
            end else begin
                ox_d = ox_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ox_q <= '0;
            oy_q <= '0;
            s_q  <= '0;
        end else begin
            ox_q <= ox_d;
            oy_q <= oy_d;
            s_q  <= s_d;
        end
    end

    // Sample s covers the 2x2 block: s[0] steps x, s[1] steps y.
    always_comb begin
        row            = ADDR_W'({oy_d, 1'b0}) + ADDR_W'(s_d[1]);
        col            = ADDR_W'({ox_d, 1'b0}) + ADDR_W'(s_d[0]);
        src_addr_nxt_o = row * ADDR_W'(SRC_W) + col;
        dst_addr_o     = ADDR_W'(oy_q) * ADDR_W'(DST_W) + ADDR_W'(ox_q);
    end

    assign last_sample_o = (mean_i == MODE_MEAN) ? (s_q == 2'd3) : 1'b1;
    assign last_pixel_o  = (ox_q == OX_W'(DST_W - 1)) && (oy_q == OY_W'(DST_H - 1));

endmodule

// File: rtl/decimation_engine.sv
// Reads the source image from a synchronous ROM, halves it in both axes (nearest or 2x2 mean)
// and writes the result into the framebuffer write port.
//   state   | meaning
//   IDLE    | waiting for start
//   ISSUE   | source address presented to the ROM
//   CAPTURE | ROM data valid, accumulate it
//   WRITE   | dst_wren high, one output pixel committed
//   DONE    | one-cycle done pulse
module decimation_engine
    import zoom_pkg::*;
#(
    parameter int SRC_W  = SRC_W_DEF,
    parameter int SRC_H  = SRC_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              avg_mode,
    output logic [ADDR_W-1:0] src_rdaddress,
    input  logic [DATA_W-1:0] src_data,
    output logic [ADDR_W-1:0] dst_wraddress,
    output logic [DATA_W-1:0] dst_data,
    output logic              dst_wren,
    output logic              busy,
    output logic              done
);

    localparam int ACC_W = DATA_W + 2;

    state_t            state_q, state_d;
    logic              mode_q;
    logic [ACC_W-1:0]  acc_q, sum, sum_rnd;
    logic [ADDR_W-1:0] src_q, dst_addr_q, src_addr_nxt, dst_addr;
    logic [DATA_W-1:0] dst_data_q;
    logic              dst_wren_q, busy_q, done_q;
    logic              clear, adv_sample, adv_pixel, load_src;
    logic              last_sample, last_pixel;

    decim_addr_gen #(
        .SRC_W  (SRC_W),
        .SRC_H  (SRC_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clock          (clock),
        .reset_n        (reset_n),
        .clear_i        (clear),
        .adv_sample_i   (adv_sample),
        .adv_pixel_i    (adv_pixel),
        .mean_i         (mode_q),
        .src_addr_nxt_o (src_addr_nxt),
        .dst_addr_o     (dst_addr),
        .last_sample_o  (last_sample),
        .last_pixel_o   (last_pixel)
    );

    assign sum     = acc_q + ACC_W'(src_data);
    assign sum_rnd = sum + ACC_W'(2);

    always_comb begin
        state_d    = state_q;
        clear      = 1'b0;
        adv_sample = 1'b0;
        adv_pixel  = 1'b0;
        load_src   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                clear    = 1'b1;
                load_src = 1'b1;
                state_d  = ISSUE;
            end
            ISSUE:   state_d = CAPTURE;
            CAPTURE: if (!last_sample) begin
                adv_sample = 1'b1;
                load_src   = 1'b1;
                state_d    = ISSUE;
            end else begin
                state_d = WRITE;
            end
            WRITE: if (last_pixel) begin
                state_d = DONE;
            end else begin
                adv_pixel = 1'b1;
                load_src  = 1'b1;
                state_d   = ISSUE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write-port registers are loaded on the CAPTURE->WRITE edge so they are valid throughout WRITE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            mode_q     <= MODE_NEAREST;
            acc_q      <= '0;
            src_q      <= '0;
            dst_addr_q <= '0;
            dst_data_q <= '0;
            dst_wren_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dst_wren_q <= 1'b0;
            done_q     <= 1'b0;
            if (load_src) src_q <= src_addr_nxt;
            case (state_q)
                IDLE: if (start) begin
                    mode_q <= avg_mode;
                    acc_q  <= '0;
                    busy_q <= 1'b1;
                end
                CAPTURE: begin
                    acc_q <= sum;
                    if (last_sample) begin
                        dst_wren_q <= 1'b1;
                        dst_addr_q <= dst_addr;
                        dst_data_q <= (mode_q == MODE_MEAN) ? sum_rnd[ACC_W-1:2] : sum[DATA_W-1:0];
                    end
                end
                WRITE: begin
                    acc_q <= '0;
                    if (last_pixel) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign src_rdaddress = src_q;
    assign dst_wraddress = dst_addr_q;
    assign dst_data      = dst_data_q;
    assign dst_wren      = dst_wren_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_decimation_engine.sv
// Directed bench for decimation_engine: ROM and framebuffer models with hand-computed pixels.
module tb_decimation_engine;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        avg_mode;
    logic [16:0] src_rdaddress;
    logic [7:0]  src_data;
    logic [16:0] dst_wraddress;
    logic [7:0]  dst_data;
    logic        dst_wren;
    logic        busy;
    logic        done;

    decimation_engine dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .avg_mode      (avg_mode),
        .src_rdaddress (src_rdaddress),
        .src_data      (src_data),
        .dst_wraddress (dst_wraddress),
        .dst_data      (dst_data),
        .dst_wren      (dst_wren),
        .busy          (busy),
        .done          (done)
    );

    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;
    int   pattern = 0;
    logic [7:0] fb [0:19199];
    int   wr_count = 0;
    int   done_cnt = 0;
    int   order_err = 0;
    int   exp_next = 0;
    int   last_wr = -1;
    int   first_wr_cyc = 0;
    int   acc_cyc = 0;
    int   wr_base, done_base, k;
    int   av [0:2];
    logic got_done;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [7:0] pix(input int a, input int pat);
        int x, y;
        x = a % 320;
        y = a / 320;
        case (pat)
            0: return 8'((x + y) & 255);
            1: return 8'(x & 255);
            default: begin
                if (x < 2 && y < 2) return (x == 1 && y == 1) ? 8'd0 : 8'd1;
                if (x >= 2 && x < 4 && y < 2) return 8'd255;
                return 8'd0;
            end
        endcase
    endfunction

    always @(posedge clock) src_data <= pix(int'(src_rdaddress), pattern);

    // Framebuffer model; a write shown in a cycle commits on the following edge.
    always @(negedge clock) begin
        if (!busy) exp_next = 0;
        if (dst_wren) begin
            if (dst_wraddress < 17'd19200) fb[dst_wraddress] = dst_data;
            if (int'(dst_wraddress) != exp_next) order_err = order_err + 1;
            if (dst_wraddress == 17'd0) first_wr_cyc = cyc + 1;
            exp_next = int'(dst_wraddress) + 1;
            last_wr  = int'(dst_wraddress);
            wr_count = wr_count + 1;
        end
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic mode);
        @(negedge clock);
        avg_mode = mode;
        start    = 1'b1;
        @(negedge clock);
        acc_cyc   = cyc;
        start     = 1'b0;
        wr_base   = wr_count;
        done_base = done_cnt;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        avg_mode = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_src_addr", int'(src_rdaddress), 0);
        chk("rst_dst_addr", int'(dst_wraddress), 0);
        chk("rst_dst_data", int'(dst_data), 0);
        chk("rst_wren", int'(dst_wren), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Mean mode, source = x: output ox averages x=2ox,2ox+1 twice -> 2ox+1.
        pattern = 1;
        start_frame(1'b1);
        chk("mean_busy", int'(busy), 1);
        av[0] = int'(src_rdaddress);
        k = 1;
        for (int i = 0; i < 40 && k < 3; i++) begin
            @(negedge clock);
            if (int'(src_rdaddress) != av[k-1]) begin
                av[k] = int'(src_rdaddress);
                k = k + 1;
            end
        end
        chk("mean_addr0", av[0], 0);
        chk("mean_addr1", (k > 1) ? av[1] : -1, 1);
        chk("mean_addr2", (k > 2) ? av[2] : -1, 320);
        for (int i = 0; i < 3000 && (wr_count - wr_base) < 128; i++) @(negedge clock);
        chk("mean_128_writes", int'((wr_count - wr_base) >= 128), 1);
        chk("mean_first_wren", first_wr_cyc - acc_cyc, 9);
        chk("mean_dst0", int'(fb[0]), 1);
        chk("mean_dst1", int'(fb[1]), 3);
        chk("mean_dst63", int'(fb[63]), 127);
        chk("mean_dst127", int'(fb[127]), 255);
        do_reset();

        // Rounding blocks, then an asynchronous reset mid-frame at cycle 1000.
        pattern = 2;
        start_frame(1'b1);
        repeat (999) @(negedge clock);
        chk("round_1110", int'(fb[0]), 1);
        chk("round_ffff", int'(fb[1]), 255);
        chk("round_zero", int'(fb[2]), 0);
        chk("pre_rst_busy", int'(busy), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_src_addr", int'(src_rdaddress), 0);
        chk("arst_dst_addr", int'(dst_wraddress), 0);
        chk("arst_dst_data", int'(dst_data), 0);
        chk("arst_wren", int'(dst_wren), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        wr_base = wr_count;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (50) @(negedge clock);
        chk("post_rst_writes", wr_count - wr_base, 0);
        chk("post_rst_busy", int'(busy), 0);

        // Nearest full frame, source = x+y; stray start and mode toggle while busy.
        pattern = 0;
        start_frame(1'b0);
        got_done = 1'b0;
        for (int i = 0; i < 60000 && !got_done; i++) begin
            @(negedge clock);
            k = cyc - acc_cyc;
            if (k == 500)   start = 1'b1;
            if (k == 501)   start = 1'b0;
            if (k == 20000) avg_mode = 1'b1;
            if (k == 57000) start = 1'b1;
            if (done) got_done = 1'b1;
        end
        chk("near_done_seen", int'(got_done), 1);
        chk("near_done_cycle", cyc - acc_cyc, 57600);
        @(negedge clock);
        chk("near_idle_busy", int'(busy), 0);
        chk("near_done_width", int'(done), 0);
        chk("near_writes", wr_count - wr_base, 19200);
        chk("near_done_count", done_cnt - done_base, 1);
        chk("near_order", order_err, 0);
        chk("near_first_wren", first_wr_cyc - acc_cyc, 3);
        chk("near_last_addr", last_wr, 19199);
        chk("near_dst0", int'(fb[0]), 0);
        chk("near_dst1", int'(fb[1]), 2);
        chk("near_dst160", int'(fb[160]), 2);
        chk("near_dst19199", int'(fb[19199]), 8'h2C);
        @(negedge clock);
        chk("restart_busy", int'(busy), 1);
        start = 1'b0;
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
